mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the pipelined core's fetch and memory-stage ports. It answers instruction fetches (PCF → InstrF) and data accesses (ALUOutM / WriteDataM → ReadDataM) from one single-ported word RAM with a programmable access latency. It generates the stall signals that the hazard unit ORs into StallF and the whole-pipeline freeze. It sits outside the datapath, between the core and the memory array.

## Interface
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles per access, including the completion cycle; legal range 1..15.
- INIT_FILE, "": hex image loaded into the RAM at elaboration if non-empty; RAM contents are not touched by reset.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCF  in  32  fetch address; upstream holds it stable while FetchStallF=1.
- InstrF  out  32  fetched instruction.
- FetchStallF  out  1  fetch not completing this cycle.
- ALUOutM  in  32  data address; held stable while MemStallM=1.
- WriteDataM  in  32  store data.
- MemWriteM  in  1  store request.
- MemReadM  in  1  load request.
- ReadDataM  out  32  load data.
- MemStallM  out  1  data request pending and not completing this cycle.

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2].
  - addr[1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS·4.
- Data request DReq = MemWriteM | MemReadM. Fetch request is always asserted.
- If MemWriteM and MemReadM are both 1, the access is a store; ReadDataM is not updated.
- State: Serving ∈ {FETCH, DATA}, plus a counter Cnt (0..LATENCY-1) and a LastServed bit.
- Addresses and store data are taken live from the ports; they are not latched.
- Completion cycle is Cnt == LATENCY-1. In that cycle:
  - FETCH: InstrF = RAM[PCF index].
  - DATA load: ReadDataM = RAM[ALUOutM index] (combinational read).
  - DATA store: RAM written at the clock edge ending the cycle.
  - The driven value is also registered. Outside completion cycles, InstrF/ReadDataM hold the last completed value.
- Non-completion cycle: Cnt increments.
- Decision at each completion edge picks the next port:
  - Only fetch pending → FETCH.
  - Both pending → the port other than the one just served (round-robin via LastServed).
  - Cnt ← 0; LastServed ← port just completed.
- No preemption: an access in progress always runs to completion.
- Stalls (combinational):
  - FetchStallF = ~(Serving==FETCH & completion).
  - MemStallM = DReq & ~(Serving==DATA & completion).
- If DReq drops while DATA is being served before completion (illegal upstream), the access still completes; a store still commits.
- Reset (at any time, including mid-access):
  - Serving=FETCH, Cnt=0, LastServed=FETCH. A data/fetch tie right after reset therefore goes to DATA.
  - InstrF=0, ReadDataM=0.
  - Any in-flight store is dropped; no RAM write.
  - FetchStallF=(LATENCY>1), MemStallM=DReq while reset is held.

## Timing
- LATENCY=1, no data traffic: one fetch completes every cycle; FetchStallF stays 0.
- Fetch latency is LATENCY cycles from the first cycle it is served.
- A data request arriving during a fetch waits for the fetch to finish, then takes LATENCY cycles. Worst-case MemStallM run is 2·LATENCY-1 cycles.
- Back-to-back accesses have no idle bubble between them.
- A store is visible to a load or fetch served in the very next access.
- Reset release: the first fetch completes in cycle LATENCY after the first rising edge with reset=1.

## Test plan
- Reset, LATENCY=1: preload word 0=0xE3A00005. Hold reset low mid-run → InstrF=0, ReadDataM=0. Release with PCF=0 → InstrF=0xE3A00005, FetchStallF=0 every cycle.
- LATENCY=3, PCF=0x8 (word 2=0x11111111) → FetchStallF=1,1,0; InstrF=0x11111111 in the 3rd cycle and held afterwards.
- LATENCY=1:
  - Store 0xDEADBEEF to 0x40.
  - Then load 0x40 → ReadDataM=0xDEADBEEF.
  - Fetch PCF=0x40 alternates with the load; FetchStallF=1 during each data slot.
- LATENCY=2, DReq raised in the 1st cycle of a fetch → fetch completes in cycle 2; data completes in cycle 4; MemStallM=1,1,1,0.
- Wrap, DEPTH_WORDS=256: store 0x12345678 to 0x404 → load 0x004 returns 0x12345678. Load 0x406 also returns it (low bits ignored).
- Reset pulse in the 2nd cycle of a LATENCY=3 store to 0x10 (old value 0xAAAAAAAA) → word 0x10 still reads 0xAAAAAAAA after restart.

Source files
------------

// File: rtl/mem_responder.sv
// Memory responder for the pipelined core: one single-ported word RAM shared
// between instruction fetch and data accesses, with programmable access latency.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        FetchStallF,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM
);

  localparam int unsigned   AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned   CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DATA  = 1'b1
  } port_e;

  logic [31:0]   r_mem [DEPTH_WORDS];
  port_e         r_serving, w_serving_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_store, w_store_nxt;
  logic [31:0]   r_instr, r_rdata;

  logic          w_dreq, w_done, w_fetch_done, w_data_done;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Address bits outside the word index are deliberately ignored.
  assign w_unused = ^{PCF[31:AW+2], PCF[1:0], ALUOutM[31:AW+2], ALUOutM[1:0]};

  always_comb begin
    w_dreq       = MemWriteM | MemReadM;
    w_done       = (r_cnt == LAST);
    w_fetch_done = (r_serving == S_FETCH) && w_done;
    w_data_done  = (r_serving == S_DATA) && w_done;
    w_idx        = (r_serving == S_FETCH) ? PCF[AW+1:2] : ALUOutM[AW+1:2];
    w_rdata      = r_mem[w_idx];
    FetchStallF  = ~w_fetch_done;
    MemStallM    = w_dreq & ~w_data_done;
    // Reset forces the registered zero onto InstrF even when LATENCY=1.
    InstrF       = (w_fetch_done && reset) ? w_rdata : r_instr;
    ReadDataM    = (w_data_done && !r_store) ? w_rdata : r_rdata;
  end

  // The port completing now is the last-served one, so the round-robin tie
  // break reduces to: data goes next only when it waited behind a fetch.
  always_comb begin
    w_serving_nxt = r_serving;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_store_nxt   = r_store;
    if (w_done) begin
      w_cnt_nxt     = '0;
      w_serving_nxt = (r_serving == S_FETCH && w_dreq) ? S_DATA : S_FETCH;
      w_store_nxt   = MemWriteM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_serving <= S_FETCH;
      r_cnt     <= '0;
      r_store   <= 1'b0;
      r_instr   <= '0;
      r_rdata   <= '0;
    end else begin
      r_serving <= w_serving_nxt;
      r_cnt     <= w_cnt_nxt;
      r_store   <= w_store_nxt;
      if (w_fetch_done) r_instr <= w_rdata;
      if (w_data_done && !r_store) r_rdata <= w_rdata;
    end
  end

  // Store kind is captured at grant so a store still commits if DReq drops.
  always_ff @(posedge clk) begin
    if (w_data_done && r_store) r_mem[w_idx] <= WriteDataM;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 2, 3) driven with directed
// scenarios and random legal traffic, checked each cycle against a reference model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcf [3];
  logic [31:0] aluo [3];
  logic [31:0] wd [3];
  logic [31:0] instr [3];
  logic [31:0] rd [3];
  logic        mw [3];
  logic        mr [3];
  logic        fst [3];
  logic        mst [3];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_n), .PCF(pcf[0]), .InstrF(instr[0]), .FetchStallF(fst[0]),
    .ALUOutM(aluo[0]), .WriteDataM(wd[0]), .MemWriteM(mw[0]), .MemReadM(mr[0]),
    .ReadDataM(rd[0]), .MemStallM(mst[0]));

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n), .PCF(pcf[1]), .InstrF(instr[1]), .FetchStallF(fst[1]),
    .ALUOutM(aluo[1]), .WriteDataM(wd[1]), .MemWriteM(mw[1]), .MemReadM(mr[1]),
    .ReadDataM(rd[1]), .MemStallM(mst[1]));

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst_n), .PCF(pcf[2]), .InstrF(instr[2]), .FetchStallF(fst[2]),
    .ALUOutM(aluo[2]), .WriteDataM(wd[2]), .MemWriteM(mw[2]), .MemReadM(mr[2]),
    .ReadDataM(rd[2]), .MemStallM(mst[2]));

  // Reference model: per instance, which port owns the RAM, how many cycles of
  // its access remain, and the memory image.
  logic [31:0] m_mem [3][256];
  int          m_left [3];
  bit          m_data [3];
  bit          m_store [3];
  logic [31:0] m_instr [3];
  logic [31:0] m_rdata [3];

  bit          ex_fst [3];
  bit          ex_mst [3];
  logic [31:0] ob_instr [3];
  logic [31:0] ob_rd [3];
  logic        ob_fst [3];
  logic        ob_mst [3];
  logic [31:0] acc_got [3];

  int checks = 0;
  int errors = 0;
  bit chk_en;

  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a & ~32'h0000_0380;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %08h expected %08h", tag, k, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied; ends at the next falling edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e_instr, e_rd;
      bit          e_fst, e_mst, dreq, fin;
      int          pw, dw;
      dreq        = mw[k] | mr[k];
      pw          = widx(pcf[k]);
      dw          = widx(aluo[k]);
      ob_instr[k] = instr[k];
      ob_rd[k]    = rd[k];
      ob_fst[k]   = fst[k];
      ob_mst[k]   = mst[k];
      if (!rst_n) begin
        e_instr    = '0;
        e_rd       = '0;
        e_fst      = (lat_of(k) > 1);
        e_mst      = dreq;
        m_left[k]  = lat_of(k);
        m_data[k]  = 1'b0;
        m_store[k] = 1'b0;
        m_instr[k] = '0;
        m_rdata[k] = '0;
      end else begin
        fin     = (m_left[k] == 1);
        e_fst   = !(fin && !m_data[k]);
        e_mst   = dreq && !(fin && m_data[k]);
        e_instr = (fin && !m_data[k]) ? m_mem[k][pw] : m_instr[k];
        e_rd    = (fin && m_data[k] && !m_store[k]) ? m_mem[k][dw] : m_rdata[k];
        if (fin) begin
          if (!m_data[k]) m_instr[k] = e_instr;
          else if (m_store[k]) m_mem[k][dw] = wd[k];
          else m_rdata[k] = e_rd;
          m_data[k]  = !m_data[k] && dreq;
          m_store[k] = mw[k];
          m_left[k]  = lat_of(k);
        end else begin
          m_left[k] = m_left[k] - 1;
        end
      end
      ex_fst[k] = e_fst;
      ex_mst[k] = e_mst;
      if (chk_en) begin
        chk("InstrF", k, ob_instr[k], e_instr);
        chk("ReadDataM", k, ob_rd[k], e_rd);
        chk("FetchStallF", k, {31'b0, ob_fst[k]}, {31'b0, e_fst});
        chk("MemStallM", k, {31'b0, ob_mst[k]}, {31'b0, e_mst});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input bit [2:0] sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data);
    bit [2:0] pend;
    for (int k = 0; k < 3; k++) begin
      if (sel[k]) begin
        mw[k] = wr; mr[k] = !wr; aluo[k] = addr; wd[k] = data;
      end
    end
    pend = sel;
    for (int c = 0; c < 40 && pend != 3'b000; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (pend[k] && !ex_mst[k]) begin
          acc_got[k] = ob_rd[k];
          pend[k] = 1'b0;
          mw[k] = 1'b0;
          mr[k] = 1'b0;
        end
      end
    end
    chk("access_timeout", 0, {29'b0, pend}, 32'b0);
  endtask

  initial begin
    bit found;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pcf[k] = '0; aluo[k] = '0; wd[k] = '0; mw[k] = 1'b0; mr[k] = 1'b0;
    end
    @(negedge clk);
    repeat (3) tick();

    // Preload words 0..31 through ordinary stores.
    rst_n  = 1'b1;
    chk_en = 1'b0;
    for (int w = 0; w < 32; w++) begin
      logic [31:0] v;
      v = $urandom;
      if (w == 0) v = 32'hE3A0_0005;
      if (w == 2) v = 32'h1111_1111;
      if (w == 4) v = 32'hAAAA_AAAA;
      access(3'b111, 1'b1, 32'(w * 4), v);
    end
    chk_en = 1'b1;

    // Reset mid-run, then release: L1 fetches word 0 every cycle, L3 fetches word 2.
    pcf[0] = 32'h0; pcf[1] = 32'h0; pcf[2] = 32'h8;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rel_instr", 0, ob_instr[0], 32'hE3A0_0005);
      chk("rel_fst", 0, {31'b0, ob_fst[0]}, 32'b0);
      chk("l3_fst", 2, {31'b0, ob_fst[2]}, (t == 2) ? 32'd0 : 32'd1);
      chk("l3_instr", 2, ob_instr[2], (t >= 2) ? 32'h1111_1111 : 32'h0);
    end

    // Reset pulse during the 2nd cycle of an L3 store: old value must survive.
    mw[2] = 1'b1; aluo[2] = 32'h10; wd[2] = 32'h5555_5555;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (m_data[2] && m_left[2] == 2) found = 1'b1;
      else tick();
    end
    chk("store_2nd_cycle", 2, {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    mw[2] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    access(3'b100, 1'b0, 32'h10, 32'h0);
    chk("store_dropped", 2, acc_got[2], 32'hAAAA_AAAA);

    // L1 store then load/fetch of the same word, alternating slots.
    access(3'b001, 1'b1, 32'h40, 32'hDEAD_BEEF);
    pcf[0] = 32'h40; mr[0] = 1'b1; aluo[0] = 32'h40;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("alt_fst", 0, {31'b0, ob_fst[0]}, 32'(t % 2));
      if (t % 2 == 0) chk("fetch40", 0, ob_instr[0], 32'hDEAD_BEEF);
      else chk("load40", 0, ob_rd[0], 32'hDEAD_BEEF);
    end
    mr[0] = 1'b0;

    // L2: load raised in the first cycle of a fetch waits 2+2 cycles.
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (!m_data[1] && m_left[1] == 2) found = 1'b1;
      else tick();
    end
    chk("fetch_1st_cycle", 1, {31'b0, found}, 32'd1);
    mr[1] = 1'b1; aluo[1] = 32'h8;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("mst_seq", 1, {31'b0, ob_mst[1]}, (t == 3) ? 32'd0 : 32'd1);
    end
    chk("ld8", 1, ob_rd[1], 32'h1111_1111);
    mr[1] = 1'b0;

    // Address wrap and ignored byte offset.
    access(3'b001, 1'b1, 32'h404, 32'h1234_5678);
    access(3'b001, 1'b0, 32'h004, 32'h0);
    chk("wrap_ld", 0, acc_got[0], 32'h1234_5678);
    access(3'b001, 1'b0, 32'h406, 32'h0);
    chk("offset_ld", 0, acc_got[0], 32'h1234_5678);

    // Random legal traffic: inputs change only when the port is not stalled.
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        int r;
        if (!ex_fst[k]) pcf[k] = rand_addr();
        if (!ex_mst[k]) begin
          r       = int'($urandom_range(0, 9));
          mw[k]   = (r < 3) || (r == 9);
          mr[k]   = (r >= 3 && r < 6) || (r == 9);
          aluo[k] = rand_addr();
          wd[k]   = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
